// File: rtl/fir_output_requantizer.sv
// rtl/fir_output_requantizer.sv - requantizes FIR accumulator output to DAC width into a show-ahead FIFO
module fir_output_requantizer #(
    parameter int IN_WIDTH   = 28,
    parameter int OUT_WIDTH  = 12,
    parameter int SHIFT      = 15,
    parameter int PIPE_FILL  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_filter_en,
    input  logic signed [IN_WIDTH-1:0]    i_fir_data,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic signed [OUT_WIDTH-1:0]   o_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    input  logic                          i_flag_clear,
    output logic                          o_sat_sticky,
    output logic                          o_overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int FILL_W = $clog2(PIPE_FILL + 2);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PIPE_FILL);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_ZERO = '0;

    localparam logic signed [IN_WIDTH:0] HALF    = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MAX = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                        en_q;
    logic [FILL_W-1:0]           fill_q, fill_d;
    logic                        q_valid_q, q_valid_d;
    logic signed [OUT_WIDTH-1:0] q_data_q, q_data_d;
    logic                        q_sat_q, q_sat_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [LVL_W-1:0]            level_q, level_d;
    logic                        valid_q, valid_d;
    logic signed [OUT_WIDTH-1:0] data_q, data_d;
    logic                        sat_q, sat_d, ovf_q, ovf_d;
    logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];

    logic signed [IN_WIDTH:0]    rounded, shifted;
    logic                        capture_ok, rd_en, wr_en, full;

    // Extra headroom bit keeps the rounding add from wrapping near full scale.
    assign rounded = {i_fir_data[IN_WIDTH-1], i_fir_data} + HALF;
    assign shifted = rounded >>> SHIFT;

    always_comb begin
        q_data_d = shifted[OUT_WIDTH-1:0];
        q_sat_d  = 1'b0;
        if (shifted > SAT_MAX) begin
            q_data_d = OUT_MAX;
            q_sat_d  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            q_data_d = OUT_MIN;
            q_sat_d  = 1'b1;
        end
    end

    assign capture_ok = en_q && (fill_q == FILL_MAX);
    assign fill_d     = (en_q && (fill_q != FILL_MAX)) ? fill_q + FILL_W'(1) : fill_q;
    assign q_valid_d  = capture_ok;

    assign rd_en   = valid_q & i_ready;
    assign full    = (level_q == LVL_FULL);
    assign wr_en   = q_valid_q & (~full | rd_en);
    assign rd_next = rd_ptr_q + PTR_W'(1);

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_next : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !rd_en) level_d = level_q + LVL_W'(1);
        else if (!wr_en && rd_en) level_d = level_q - LVL_W'(1);
        valid_d = (level_d != LVL_ZERO);

        // Output register tracks the next head; it holds the last read value once empty.
        data_d = data_q;
        if (rd_en) begin
            if (level_q == LVL_ONE) data_d = wr_en ? q_data_q : data_q;
            else                    data_d = mem[rd_next];
        end else if (wr_en && level_q == LVL_ZERO) begin
            data_d = q_data_q;
        end

        sat_d = sat_q;
        if (wr_en && q_sat_q) sat_d = 1'b1;
        else if (i_flag_clear) sat_d = 1'b0;

        ovf_d = ovf_q;
        if (q_valid_q && full && !rd_en) ovf_d = 1'b1;
        else if (i_flag_clear) ovf_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            en_q      <= 1'b0;
            fill_q    <= '0;
            q_valid_q <= 1'b0;
            q_data_q  <= '0;
            q_sat_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            sat_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            en_q      <= i_filter_en;
            fill_q    <= fill_d;
            q_valid_q <= q_valid_d;
            if (capture_ok) begin
                q_data_q <= q_data_d;
                q_sat_q  <= q_sat_d;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sat_q     <= sat_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr_q] <= q_data_q;
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_level      = level_q;
    assign o_sat_sticky = sat_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_fir_output_requantizer.sv
// tb/tb_fir_output_requantizer.sv - scoreboard bench for fir_output_requantizer
module tb_fir_output_requantizer;

    localparam int IW = 28;
    localparam int OW = 12;

    logic                 i_clk = 1'b0;
    logic                 i_reset, i_filter_en, i_ready, i_flag_clear;
    logic signed [IW-1:0] i_fir_data;
    logic                 o_valid, o_sat_sticky, o_overflow;
    logic signed [OW-1:0] o_data;
    logic [2:0]           o_level;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic signed [IW-1:0] pending;

    always #5 i_clk = ~i_clk;

    fir_output_requantizer dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_filter_en  (i_filter_en),
        .i_fir_data   (i_fir_data),
        .i_ready      (i_ready),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_level      (o_level),
        .i_flag_clear (i_flag_clear),
        .o_sat_sticky (o_sat_sticky),
        .o_overflow   (o_overflow)
    );

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // The filter output changes on the edge that samples the strobe, so data lags the strobe by one cycle.
    task automatic step(input logic en, input logic signed [IW-1:0] d);
        @(posedge i_clk);
        #1;
        i_fir_data  = pending;
        i_filter_en = en;
        pending     = d;
    endtask

    task automatic strobe(input logic signed [IW-1:0] d, input bit push, input int exp);
        step(1'b1, d);
        if (push) exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0);
    endtask

    task automatic clear_flags();
        i_flag_clear = 1'b1;
        step(1'b0, '0);
        i_flag_clear = 1'b0;
    endtask

    always @(negedge i_clk) begin
        if (i_reset === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got %0d expected none", o_data);
            end else begin
                chk("sample", o_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        i_reset      = 1'b0;
        i_filter_en  = 1'b0;
        i_fir_data   = '0;
        i_ready      = 1'b0;
        i_flag_clear = 1'b0;
        pending      = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_level", o_level, 0);
        chk("rst_sat", o_sat_sticky, 0);
        chk("rst_ovf", o_overflow, 0);
        i_reset = 1'b1;

        // fill discard and latency
        i_ready = 1'b1;
        strobe(0, 0, 0);
        strobe(0, 0, 0);
        strobe(98304, 1, 3);
        step(1'b0, '0);
        @(negedge i_clk) chk("lat_e0_valid", o_valid, 0);
        step(1'b0, '0);
        @(negedge i_clk) chk("lat_e1_valid", o_valid, 0);
        step(1'b0, '0);
        @(negedge i_clk) chk("lat_e2_valid", o_valid, 1);
        chk("lat_e2_data", o_data, 3);
        step(1'b0, '0);
        @(negedge i_clk) chk("lat_e3_valid", o_valid, 0);

        // rounding
        strobe(16384, 1, 1);
        strobe(16383, 1, 0);
        strobe(-16384, 1, 0);
        strobe(-16385, 1, -1);
        strobe(-98304, 1, -3);
        idle(5);
        chk("round_sat", o_sat_sticky, 0);

        // saturation and sticky clear
        strobe((2**27) - 1, 1, 2047);
        strobe(-(2**27), 1, -2048);
        idle(5);
        chk("sat_set", o_sat_sticky, 1);
        clear_flags();
        @(negedge i_clk) chk("sat_cleared", o_sat_sticky, 0);

        // full and overflow
        i_ready = 1'b0;
        for (int k = 1; k <= 6; k++) strobe(32768 * k, (k <= 4), k);
        idle(4);
        chk("full_level", o_level, 4);
        chk("full_ovf", o_overflow, 1);
        chk("full_sat", o_sat_sticky, 0);
        i_ready = 1'b1;
        idle(6);
        chk("drain_valid", o_valid, 0);
        chk("drain_level", o_level, 0);
        chk("drain_hold", o_data, 4);
        chk("drain_queue", exp_q.size(), 0);

        // simultaneous read and write at full
        i_ready = 1'b0;
        clear_flags();
        for (int k = 1; k <= 4; k++) strobe(32768 * k, 1, k);
        idle(3);
        chk("rw_pre_level", o_level, 4);
        strobe(32768 * 5, 1, 5);
        step(1'b0, '0);
        step(1'b0, '0);
        i_ready = 1'b1;
        step(1'b0, '0);
        i_ready = 1'b0;
        @(negedge i_clk);
        chk("rw_level", o_level, 4);
        chk("rw_ovf", o_overflow, 0);
        i_ready = 1'b1;
        idle(6);
        chk("rw_queue", exp_q.size(), 0);

        // reset mid-stream
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) strobe(32768 * k, 0, 0);
        step(1'b0, '0);
        step(1'b0, '0);
        chk("mid_level", o_level, 3);
        chk("mid_qvalid", dut.q_valid_q, 1);
        #1;
        i_reset = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_level", o_level, 0);
        chk("mid_rst_sat", o_sat_sticky, 0);
        chk("mid_rst_ovf", o_overflow, 0);
        idle(2);
        i_reset = 1'b1;
        i_ready = 1'b1;
        strobe(32768 * 7, 0, 0);
        strobe(32768 * 8, 0, 0);
        strobe(32768 * 9, 1, 9);
        idle(6);
        chk("post_rst_queue", exp_q.size(), 0);
        chk("post_rst_hold", o_data, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
